// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the sequential multi-word adder.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice build still needs a one-bit index.
  function automatic int idx_width(input int words);
    int w;
    if (words <= 1) begin
      w = 1;
    end else begin
      w = $clog2(words);
    end
    return w;
  endfunction

endpackage

// File: rtl/multiword_add_seq_cla_slice.sv
// One WIDTH-bit carry-lookahead adder slice; purely combinational.
module cla_slice #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] gg_s;
  logic [WIDTH-1:0] pp_s;
  logic [WIDTH:0]   c_s;

  // Group generate/propagate prefix over bits [i:0], then every carry is G + P*cin.
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    gg_s    = {WIDTH{1'b0}};
    pp_s    = {WIDTH{1'b0}};
    c_s     = {(WIDTH+1){1'b0}};
    gg_s[0] = g_s[0];
    pp_s[0] = p_s[0];
    for (int i = 1; i < WIDTH; i++) begin
      gg_s[i] = g_s[i] | (p_s[i] & gg_s[i-1]);
      pp_s[i] = p_s[i] & pp_s[i-1];
    end
    c_s[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c_s[i+1] = gg_s[i] | (pp_s[i] & cin);
    end
    s    = p_s ^ c_s[WIDTH-1:0];
    cout = c_s[WIDTH];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential WIDTH*WORDS-bit adder, one slice per cycle, LS slice first.
// Define MULTIWORD_ADD_SUB_EN to add the 'sub' port (a - b - cin).
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int IW    = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t            state_r;
  logic [IW-1:0]     idx_r;
  logic              carry_r;
  logic [TOTAL-1:0]  a_r;
  logic [TOTAL-1:0]  b_r;
  logic [TOTAL-1:0]  s_r;
  logic              cout_r;
  logic              out_valid_r;
  logic              in_ready_r;

  logic [WIDTH-1:0]  a_slice_s;
  logic [WIDTH-1:0]  b_slice_s;
  logic [WIDTH-1:0]  sum_s;
  logic              slice_cout_s;

  // Route the slice selected by the current index into the shared adder.
  always_comb begin
    a_slice_s = a_r[idx_r*WIDTH +: WIDTH];
    b_slice_s = b_r[idx_r*WIDTH +: WIDTH];
  end

  cla_slice #(.WIDTH(WIDTH)) u_slice (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (slice_cout_s)
  );

  // Control FSM and datapath registers; in_ready/out_valid are registered copies of the state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {TOTAL{1'b0}};
      b_r         <= {TOTAL{1'b0}};
      s_r         <= {TOTAL{1'b0}};
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
`ifdef MULTIWORD_ADD_SUB_EN
            b_r        <= sub ? ~b : b;
            carry_r    <= sub ? ~cin : cin;
`else
            b_r        <= b;
            carry_r    <= cin;
`endif
            idx_r      <= {IW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          s_r[idx_r*WIDTH +: WIDTH] <= sum_s;
          carry_r                   <= slice_cout_s;
          if (idx_r == LAST_IDX) begin
            cout_r      <= slice_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          // s/cout hold here; the next operand set is only taken once back in IDLE.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          idx_r       <= {IW{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign cout      = cout_r;

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequential multi-word adder. Adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per cycle, least significant slice first.
- The carry out of each slice is registered and fed into the next slice.
- Sits upstream of the result consumers and owns the carry-lookahead slice datapath. Valid/ready handshakes on both the input and the output side.

Parameters:
- WIDTH, 32, bit width of one adder slice.
- WORDS, 4, number of slices; total operand width TOTAL = WIDTH*WORDS. WORDS >= 1.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- a  input  TOTAL  operand A.
- b  input  TOTAL  operand B.
- cin  input  1  carry into slice 0.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result.
- s  output  TOTAL  sum, registered.
- cout  output  1  carry out of the top slice, registered.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, slice index=0, carry register=0, s=0, cout=0, out_valid=0.
  - in_ready is decoded from state (IDLE), so it reads 1 while rst is asserted.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - latch a, b into operand registers;
    - carry register <= cin; index <= 0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - slice k = index;
    - s[k*WIDTH +: WIDTH] <= a_k + b_k + carry;
    - carry <= slice carry out.
    - If index==WORDS-1: cout <= slice carry out, go to DONE. Otherwise index <= index+1.
  - DONE: out_valid=1, in_ready=0; s and cout stable.
    - On out_ready: go to IDLE, out_valid drops next cycle.
- Latency and throughput:
  - Operand accept at edge N; out_valid high after edge N+WORDS.
  - One operand set per WORDS+2 cycles minimum. No accept in the same cycle as the output handshake.
- Operand isolation: a, b, cin are sampled only at accept; later input changes are ignored.
- Arithmetic: unsigned modulo 2^TOTAL; cout is the true carry of the full-width addition.
- Result holding:
  - s keeps its last result through IDLE until overwritten slice by slice in the next RUN.
  - Consumers use s only while out_valid=1.
- Boundary conditions:
  - WORDS=1: RUN lasts exactly one cycle.
  - out_ready while out_valid=0: ignored.
  - in_valid outside IDLE: ignored, not queued.
  - rst mid-RUN or in DONE: abort immediately to reset values; no out_valid for the aborted operation.
  - Index never wraps: RUN exits at WORDS-1.

Optional Feature:
- Macro MULTIWORD_ADD_SUB_EN.
- Defined:
  - Extra port sub (input, 1), sampled at accept with the operands.
  - When sub=1, the latched B is ~b and the initial carry is ~cin, giving a - b - cin.
  - cout=1 means no borrow.
- Undefined: no sub port, add only.

Decomposition:
- Package multiword_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the index width function, clog2(WORDS) with minimum 1.
- Sub-module cla_slice: combinational WIDTH-bit carry-lookahead adder (a, b, cin -> s, cout).
  - Uses per-bit generate/propagate, group G/P prefix, cout = G + P·cin.
  - Instantiated once and muxed by index.

Test Plan:
- Full carry ripple: a=all ones (128 b), b=1, cin=0, out_ready=1 -> s=0, cout=1; out_valid first high exactly 4 cycles after the accept edge.
- Carry-in only: a=0, b=0, cin=1 -> s=1, cout=0.
- Single boundary carry: a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1 -> s=0x...0001_0000_0000, cout=0; slices 2-3 zero.
- Backpressure: out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands -> s/cout constant, in_ready=0, no second accept.
  - Then out_ready=1 for one cycle -> IDLE; next operands accepted the following cycle.
- Reset mid-RUN: assert rst after the second RUN cycle -> out_valid stays 0, s=0, cout=0, in_ready=1 while rst is asserted and after release.
- MULTIWORD_ADD_SUB_EN: a=5, b=7, cin=0, sub=1 -> s=0xFFFF…FFFE, cout=0. Repeat with a=7, b=5 -> s=2, cout=1.
